mips_dbg_sequencer: RTL and testbench

Command sequencer for the MIPS debug path: pops command bytes from the UART receive FIFO, drives the pipeline enable and the auxiliary MIPS reset, snapshots the pipeline/debug words and streams them back through the UART transmit FIFO. It sits between the `uart` block and the `MIPS` core, on the 25 MHz clock, and replaces ad-hoc control of `mdb_ena` / `reset_aux`.

---
 rtl/mips_dbg_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mips_dbg_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dbg_sequencer.sv
// UART-driven debug sequencer for the MIPS core: decodes R/S/D/X commands,
// gates the pipeline, pulses the aux reset and streams status plus a dump.
module mips_dbg_sequencer #(
   parameter int N_WORDS   = 8,
   parameter int DBIT      = 8,
   parameter int RUN_LIMIT = 1048576
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx_empty,
   input  logic [DBIT-1:0]        rx_data,
   output logic                   rd_uart,
   input  logic                   tx_full,
   output logic [DBIT-1:0]        tx_data,
   output logic                   wr_uart,
   input  logic                   pc_end,
   input  logic [32*N_WORDS-1:0]  dump_words,
   output logic                   step_ena,
   output logic                   mips_rst,
   output logic                   busy
);

   localparam int RW = $clog2(RUN_LIMIT + 1);
   localparam int BW = $clog2(4 * N_WORDS);
   localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LIMIT - 1);
   localparam logic [BW-1:0] LAST_B  = BW'(4 * N_WORDS - 1);
   localparam logic [DBIT-1:0] CMD_R = DBIT'(8'h52);
   localparam logic [DBIT-1:0] CMD_S = DBIT'(8'h53);
   localparam logic [DBIT-1:0] CMD_D = DBIT'(8'h44);
   localparam logic [DBIT-1:0] CMD_X = DBIT'(8'h58);

   typedef enum logic [2:0] {
      IDLE, DECODE, RUN, STEP, CRST, LATCH, SEND_ST, SEND_DAT
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [DBIT-1:0]       r_cmd, w_cmd;
   logic [RW-1:0]         r_run_cnt, w_run_cnt;
   logic                  r_rst_cnt, w_rst_cnt;
   logic [BW-1:0]         r_byte_cnt, w_byte_cnt;
   logic [32*N_WORDS-1:0] r_shadow, w_shadow;
   logic                  r_st_err, w_st_err;
   logic                  r_st_tmo, w_st_tmo;
   logic                  r_st_end, w_st_end;
   logic                  r_rd, w_rd;
   logic                  r_wr, w_wr;
   logic [DBIT-1:0]       r_tx, w_tx;
   logic                  r_step, w_step;
   logic                  r_mrst, w_mrst;
   logic                  r_busy, w_busy;
   logic [7:0]            w_byte;

   assign rd_uart  = r_rd;
   assign wr_uart  = r_wr;
   assign tx_data  = r_tx;
   assign step_ena = r_step;
   assign mips_rst = r_mrst;
   assign busy     = r_busy;

   assign w_byte = r_shadow[{r_byte_cnt, 3'b000} +: 8];

   always_comb begin
      w_state_nxt = r_state;
      w_cmd       = r_cmd;
      w_run_cnt   = r_run_cnt;
      w_rst_cnt   = r_rst_cnt;
      w_byte_cnt  = r_byte_cnt;
      w_shadow    = r_shadow;
      w_st_err    = r_st_err;
      w_st_tmo    = r_st_tmo;
      w_st_end    = r_st_end;
      w_tx        = r_tx;
      w_rd        = 1'b0;
      w_wr        = 1'b0;
      w_step      = 1'b0;
      w_mrst      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!rx_empty) begin
               w_rd        = 1'b1;
               w_cmd       = rx_data;
               w_state_nxt = DECODE;
            end
         end
         DECODE: begin
            if (r_cmd == CMD_R) begin
               if (pc_end) begin
                  w_state_nxt = LATCH;
               end else begin
                  w_run_cnt   = '0;
                  w_step      = 1'b1;
                  w_state_nxt = RUN;
               end
            end else if (r_cmd == CMD_S) begin
               w_step      = 1'b1;
               w_state_nxt = STEP;
            end else if (r_cmd == CMD_D) begin
               w_state_nxt = LATCH;
            end else if (r_cmd == CMD_X) begin
               w_mrst      = 1'b1;
               w_rst_cnt   = 1'b0;
               w_state_nxt = CRST;
            end else begin
               w_st_err    = 1'b1;
               w_state_nxt = SEND_ST;
            end
         end
         RUN: begin
            w_run_cnt = r_run_cnt + 1'b1;
            // pc_end wins over the timeout when both land together
            if (pc_end) begin
               w_state_nxt = LATCH;
            end else if (r_run_cnt == RUN_MAX) begin
               w_st_tmo    = 1'b1;
               w_state_nxt = LATCH;
            end else begin
               w_step = 1'b1;
            end
         end
         STEP: begin
            w_state_nxt = LATCH;
         end
         CRST: begin
            w_rst_cnt = 1'b1;
            if (r_rst_cnt) w_state_nxt = SEND_ST;
            else           w_mrst      = 1'b1;
         end
         LATCH: begin
            w_shadow    = dump_words;
            w_st_end    = pc_end;
            w_byte_cnt  = '0;
            w_state_nxt = SEND_ST;
         end
         SEND_ST: begin
            if (!tx_full) begin
               w_wr     = 1'b1;
               w_tx     = DBIT'({5'b0, r_st_err, r_st_tmo, r_st_end});
               w_st_err = 1'b0;
               w_st_tmo = 1'b0;
               w_st_end = 1'b0;
               if (r_cmd == CMD_R || r_cmd == CMD_S || r_cmd == CMD_D)
                  w_state_nxt = SEND_DAT;
               else
                  w_state_nxt = IDLE;
            end
         end
         SEND_DAT: begin
            if (!tx_full) begin
               w_wr       = 1'b1;
               w_tx       = DBIT'(w_byte);
               w_byte_cnt = r_byte_cnt + 1'b1;
               if (r_byte_cnt == LAST_B) w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      w_busy = (w_state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_cmd      <= '0;
         r_run_cnt  <= '0;
         r_rst_cnt  <= 1'b0;
         r_byte_cnt <= '0;
         r_shadow   <= '0;
         r_st_err   <= 1'b0;
         r_st_tmo   <= 1'b0;
         r_st_end   <= 1'b0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_tx       <= '0;
         r_step     <= 1'b0;
         r_mrst     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cmd      <= w_cmd;
         r_run_cnt  <= w_run_cnt;
         r_rst_cnt  <= w_rst_cnt;
         r_byte_cnt <= w_byte_cnt;
         r_shadow   <= w_shadow;
         r_st_err   <= w_st_err;
         r_st_tmo   <= w_st_tmo;
         r_st_end   <= w_st_end;
         r_rd       <= w_rd;
         r_wr       <= w_wr;
         r_tx       <= w_tx;
         r_step     <= w_step;
         r_mrst     <= w_mrst;
         r_busy     <= w_busy;
      end
   end

endmodule

// File: tb/tb_mips_dbg_sequencer.sv
// Scoreboard bench for mips_dbg_sequencer: random commands, expected frames
// built from the command rules and compared by a negedge monitor.
module tb_mips_dbg_sequencer;

   localparam int N_WORDS   = 8;
   localparam int RUN_LIMIT = 128;
   localparam int NB        = 4 * N_WORDS;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  rx_empty = 1'b1;
   logic [7:0]            rx_data = 8'h00;
   logic                  rd_uart;
   logic                  tx_full = 1'b0;
   logic [7:0]            tx_data;
   logic                  wr_uart;
   logic                  pc_end = 1'b0;
   logic [32*N_WORDS-1:0] dump_words = '0;
   logic                  step_ena;
   logic                  mips_rst;
   logic                  busy;

   int total = 0;
   int bad   = 0;
   int step_cnt = 0;
   int mrst_cnt = 0;
   int wr_cnt   = 0;
   bit prev_full = 1'b0;
   logic [7:0]  sb[$];
   logic [31:0] wd[N_WORDS];

   mips_dbg_sequencer #(
      .N_WORDS(N_WORDS), .DBIT(8), .RUN_LIMIT(RUN_LIMIT)
   ) dut (
      .clk(clk), .reset(reset),
      .rx_empty(rx_empty), .rx_data(rx_data), .rd_uart(rd_uart),
      .tx_full(tx_full), .tx_data(tx_data), .wr_uart(wr_uart),
      .pc_end(pc_end), .dump_words(dump_words),
      .step_ena(step_ena), .mips_rst(mips_rst), .busy(busy)
   );

   always #20 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, exp);
      end
   endtask

   // monitor: pops the scoreboard on every TX push
   always @(negedge clk) begin
      logic [7:0] e;
      if (wr_uart) begin
         wr_cnt++;
         total++;
         if (prev_full) begin
            bad++;
            $display("FAIL push_while_full got=%02h want=no_push", tx_data);
         end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_push got=%02h want=none", tx_data);
         end else begin
            e = sb.pop_front();
            if (tx_data !== e) begin
               bad++;
               $display("FAIL tx_byte got=%02h want=%02h", tx_data, e);
            end
         end
      end
      if (step_ena) step_cnt++;
      if (mips_rst) mrst_cnt++;
      prev_full = tx_full;
   end

   task automatic load_words(input bit ramp);
      for (int k = 0; k < N_WORDS; k++) begin
         wd[k] = ramp ? 32'(k) : $urandom;
         dump_words[32*k +: 32] = wd[k];
      end
   endtask

   task automatic push_frame(input logic [7:0] st, input bit data);
      sb.push_back(st);
      if (data)
         for (int k = 0; k < NB; k++)
            sb.push_back(8'(wd[k/4] >> (8 * (k % 4))));
   endtask

   task automatic present(input logic [7:0] c);
      int i;
      @(posedge clk); #1;
      rx_data  = c;
      rx_empty = 1'b0;
      for (i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rd_uart) break;
      end
      chk("rd_latency", i, 1);
      @(posedge clk); #1;
      rx_empty = 1'b1;
   endtask

   task automatic do_cmd(input logic [7:0] c, input bit ramp,
                         input bit pc_lvl, input int pc_at,
                         input bit noise, input bit stall);
      logic [7:0] st;
      int ex_step, ex_mrst, s0, m0, w0, en, left;
      bit data, done, stalled;
      load_words(ramp);
      pc_end  = pc_lvl;
      st      = 8'h00;
      ex_step = 0;
      ex_mrst = 0;
      data    = 1'b0;
      case (c)
         8'h44: begin st = {7'b0, pc_lvl}; data = 1'b1; end
         8'h53: begin st = {7'b0, pc_lvl}; data = 1'b1; ex_step = 1; end
         8'h52: begin
            data = 1'b1;
            if (pc_lvl) st = 8'h01;
            else if (pc_at > 0) begin ex_step = pc_at + 1; st = 8'h01; end
            else begin ex_step = RUN_LIMIT; st = 8'h02; end
         end
         8'h58: ex_mrst = 2;
         default: st = 8'h04;
      endcase
      push_frame(st, data);
      s0 = step_cnt;
      m0 = mrst_cnt;
      w0 = wr_cnt;
      present(c);
      if (c == 8'h53 || (c == 8'h52 && !pc_lvl)) begin
         @(negedge clk);
         chk("step_latency", {31'b0, step_ena}, 1);
      end
      done    = 1'b0;
      stalled = 1'b0;
      left    = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk); #1;
         if (sb.size() == 0 && !busy) begin done = 1'b1; break; end
         en = step_cnt - s0;
         @(posedge clk); #1;
         if (c == 8'h52 && !pc_lvl && pc_at > 0 && en == pc_at)
            pc_end = 1'b1;
         if (stall && !stalled && wr_cnt - w0 >= 10) begin
            tx_full = 1'b1;
            stalled = 1'b1;
            left    = 50;
         end else if (left > 0) begin
            left--;
            if (left == 0) tx_full = 1'b0;
         end else if (noise) begin
            tx_full = ($urandom_range(0, 3) == 0);
         end
      end
      chk("frame_done", {31'b0, done}, 1);
      pc_end  = 1'b0;
      tx_full = 1'b0;
      chk("step_cycles", step_cnt - s0, ex_step);
      chk("mrst_cycles", mrst_cnt - m0, ex_mrst);
      if (!done) sb.delete();
   endtask

   initial begin
      logic [7:0] c;
      int w0;
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd", {31'b0, rd_uart}, 0);
      chk("rst_wr", {31'b0, wr_uart}, 0);
      chk("rst_step", {31'b0, step_ena}, 0);
      chk("rst_mrst", {31'b0, mips_rst}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_tx", tx_data, 0);
      @(posedge clk); #1 reset = 1'b1;

      do_cmd(8'h44, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      do_cmd(8'h53, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      do_cmd(8'h53, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      do_cmd(8'h52, 1'b0, 1'b0, 100, 1'b0, 1'b0);
      do_cmd(8'h52, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      do_cmd(8'h52, 1'b0, 1'b0, RUN_LIMIT - 1, 1'b0, 1'b0);
      do_cmd(8'h52, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      do_cmd(8'h41, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      do_cmd(8'h58, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      do_cmd(8'h44, 1'b0, 1'b0, 0, 1'b0, 1'b1);

      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 4))
            0: c = 8'h44;
            1: c = 8'h53;
            2: c = 8'h52;
            3: c = 8'h58;
            default: c = 8'($urandom);
         endcase
         do_cmd(c, 1'b0, 1'($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0) ? 0
                                            : $urandom_range(3, RUN_LIMIT - 1),
                1'($urandom), 1'b0);
      end

      load_words(1'b0);
      push_frame(8'h00, 1'b1);
      w0 = wr_cnt;
      present(8'h44);
      for (int cyc = 0; cyc < 200 && wr_cnt - w0 < 5; cyc++)
         @(negedge clk);
      chk("pushes_before_reset", 32'(wr_cnt - w0 >= 5), 1);
      @(posedge clk); #5;
      reset = 1'b0;
      #1;
      chk("mid_rst_rd", {31'b0, rd_uart}, 0);
      chk("mid_rst_wr", {31'b0, wr_uart}, 0);
      chk("mid_rst_step", {31'b0, step_ena}, 0);
      chk("mid_rst_mrst", {31'b0, mips_rst}, 0);
      chk("mid_rst_busy", {31'b0, busy}, 0);
      chk("mid_rst_tx", tx_data, 0);
      sb.delete();
      @(posedge clk); #1 reset = 1'b1;
      do_cmd(8'h44, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      do_cmd(8'h53, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
